// File: rtl/song_reader.sv
// rtl/song_reader.sv - walks a song's note list in the song ROM and hands notes to the note timer.
// Fetch -> wait one ROM cycle -> issue strobe -> wait for the timer, until a marker or the last slot.
module song_reader #(
  parameter int NOTES_PER_SONG_LOG2 = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [1:0]                     song,
  input  logic                           note_done,
  input  logic                           beat,
  output logic [NOTES_PER_SONG_LOG2+1:0] rom_addr,
  input  logic [11:0]                    rom_data,
  output logic [5:0]                     note,
  output logic [5:0]                     duration,
  output logic                           new_note,
  output logic                           song_done,
  output logic                           busy
);

  localparam int IW = NOTES_PER_SONG_LOG2;
  localparam logic [IW-1:0] IDX_LAST = '1;
  localparam logic [IW-1:0] IDX_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ROM_WAIT,
    S_ISSUE,
    S_WAIT_NOTE,
    S_DONE,
    S_END
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [1:0]    song_q, song_q_n;
  logic [5:0]    note_n, duration_n;

  // The timer paces itself from beat; the sequencer never needs it.
  logic unused_beat;
  assign unused_beat = beat;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    song_q_n   = song_q;
    note_n     = note;
    duration_n = duration;
    case (state)
      S_IDLE: begin
        idx_n = '0;
        if (play) begin
          state_n  = S_FETCH;
          song_q_n = song;
        end
      end
      S_FETCH:    state_n = S_ROM_WAIT;
      S_ROM_WAIT: begin
        // A zero duration is the end-of-song marker and is never issued.
        if (rom_data[5:0] == 6'd0) begin
          state_n = S_DONE;
        end else begin
          note_n     = rom_data[11:6];
          duration_n = rom_data[5:0];
          state_n    = S_ISSUE;
        end
      end
      S_ISSUE:    state_n = S_WAIT_NOTE;
      S_WAIT_NOTE: begin
        if (note_done && play) begin
          if (idx == IDX_LAST) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + IDX_ONE;
            state_n = S_FETCH;
          end
        end
      end
      S_DONE:     state_n = S_END;
      S_END: begin
        if (!play) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end
      end
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      song_q   <= '0;
      note     <= '0;
      duration <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      song_q   <= song_q_n;
      note     <= note_n;
      duration <= duration_n;
    end
  end

  assign rom_addr  = {song_q, idx};
  assign new_note  = (state == S_ISSUE);
  assign song_done = (state == S_DONE);
  assign busy      = (state != S_IDLE) && (state != S_END);

endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - song_reader bench: timeline reference model, ROM and timer models, directed scenarios.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic [1:0]  song = 2'd0;
  logic        note_done;
  logic        beat = 1'b0;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note, duration;
  logic        new_note, song_done, busy;

  song_reader #(.NOTES_PER_SONG_LOG2(5)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .beat(beat), .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
    .duration(duration), .new_note(new_note), .song_done(song_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Song ROM: registered read, data valid one cycle after the address.
  logic [11:0] rom [0:127];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Note timer: loads duration*cpb cycles on new_note, counts only while playing.
  int   cpb;
  int   tcnt = 0;
  int   bphase = 0;
  logic timer_zero = 1'b1;
  logic force_done = 1'b0;
  assign note_done = force_done | timer_zero;

  initial begin
    forever begin
      @(negedge clk);
      if (new_note === 1'b1) tcnt = int'(duration) * cpb;
      else if (play && tcnt > 0) tcnt = tcnt - 1;
      @(posedge clk);
      #1;
      timer_zero = (tcnt == 0);
      bphase = (bphase + 1) % cpb;
      beat = (bphase == 0);
    end
  end

  logic rand_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) play = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event (cycle %0d)", nm, cyc);
  endtask

  // Monitor of issued notes and end-of-song pulses.
  logic [18:0] nn_q[$];
  int          nn_cyc_q[$];
  int          done_cnt = 0;
  logic [6:0]  sd_addr = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (new_note === 1'b1) begin
        nn_q.push_back({rom_addr, note, duration});
        nn_cyc_q.push_back(cyc);
      end
      if (song_done === 1'b1) begin
        done_cnt++;
        sd_addr = rom_addr;
      end
    end
  end

  // Reference model: a straight-line walk of the song timeline, one tick per cycle.
  logic [5:0] m_note, m_dur;
  logic [1:0] m_sq;
  logic [6:0] e_addr;
  logic       e_nn, e_sd, e_busy;
  logic       s_reset, s_play, s_nd;
  logic [1:0] s_song;

  task automatic set_exp(input logic [6:0] a, input logic nn, input logic sd, input logic b);
    e_addr = a; e_nn = nn; e_sd = sd; e_busy = b;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("rom_addr", 32'(rom_addr), 32'(e_addr));
    chk("note", 32'(note), 32'(m_note));
    chk("duration", 32'(duration), 32'(m_dur));
    chk("new_note", 32'(new_note), 32'(e_nn));
    chk("song_done", 32'(song_done), 32'(e_sd));
    chk("busy", 32'(busy), 32'(e_busy));
    s_reset = reset; s_play = play; s_nd = note_done; s_song = song;
  endtask

  task automatic finish_song(input logic [4:0] ix);
    set_exp({m_sq, ix}, 1'b0, 1'b1, 1'b1);
    tick();
    if (s_reset) return;
    do begin
      set_exp({m_sq, ix}, 1'b0, 1'b0, 1'b0);
      tick();
      if (s_reset) return;
    end while (s_play);
  endtask

  task automatic run_song();
    logic [11:0] w;
    m_sq = s_song;
    for (int i = 0; i < 32; i++) begin
      set_exp({m_sq, i[4:0]}, 1'b0, 1'b0, 1'b1);
      tick();
      if (s_reset) return;
      tick();
      if (s_reset) return;
      w = rom[{m_sq, i[4:0]}];
      if (w[5:0] == 6'd0) begin
        finish_song(i[4:0]);
        return;
      end
      m_note = w[11:6];
      m_dur  = w[5:0];
      set_exp({m_sq, i[4:0]}, 1'b1, 1'b0, 1'b1);
      tick();
      if (s_reset) return;
      do begin
        set_exp({m_sq, i[4:0]}, 1'b0, 1'b0, 1'b1);
        tick();
        if (s_reset) return;
      end while (!(s_nd && s_play));
    end
    finish_song(5'd31);
  endtask

  initial begin
    m_note = '0; m_dur = '0; m_sq = '0;
    forever begin
      set_exp({m_sq, 5'd0}, 1'b0, 1'b0, 1'b0);
      tick();
      if (!s_reset && s_play) run_song();
      if (s_reset) begin
        m_note = '0; m_dur = '0; m_sq = '0;
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_nn(input int target);
    for (int k = 0; k < 5000 && nn_q.size() < target; k++) cyc_wait(1);
    if (nn_q.size() < target) timeout("wait_new_note");
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 20000 && done_cnt < target; k++) cyc_wait(1);
    if (done_cnt < target) timeout("wait_song_done");
  endtask

  task automatic clear_q();
    nn_q.delete();
    nn_cyc_q.delete();
  endtask

  initial begin
    int   c, d0;
    logic in_range;
    cpb = $urandom_range(1, 3);
    for (int a = 0; a < 128; a++) rom[a] = {6'($urandom), 6'($urandom_range(1, 3))};
    rom[10] = {6'h3F, 6'd0};
    rom[32] = {6'h10, 6'd2};
    rom[33] = {6'h12, 6'd3};
    rom[34] = {6'h14, 6'd1};
    rom[35] = {6'h2A, 6'd0};
    rom[64 + $urandom_range(2, 6)] = {6'h05, 6'd0};

    cyc_wait(3);
    reset = 1'b0;
    cyc_wait(2);

    // Three-note song, first-note latency, END hold.
    song = 2'd1;
    play = 1'b1;
    c = cyc;
    wait_done(1);
    chk("s1_count", 32'(nn_q.size()), 32'd3);
    if (nn_q.size() >= 3) begin
      chk("s1_note0", 32'(nn_q[0]), 32'({7'h20, 6'h10, 6'd2}));
      chk("s1_note1", 32'(nn_q[1]), 32'({7'h21, 6'h12, 6'd3}));
      chk("s1_note2", 32'(nn_q[2]), 32'({7'h22, 6'h14, 6'd1}));
      chk("s1_first_latency", 32'(nn_cyc_q[0]), 32'(c + 3));
    end
    chk("s1_marker_addr", 32'(sd_addr), 32'h23);
    chk("s1_busy_end", 32'(busy), 32'd0);
    cyc_wait(10);
    chk("end_hold_count", 32'(nn_q.size()), 32'd3);
    chk("end_hold_done", 32'(done_cnt), 32'd1);
    chk("end_hold_busy", 32'(busy), 32'd0);
    play = 1'b0;
    cyc_wait(3);

    // Song latch: change song during playback of song 0.
    clear_q();
    song = 2'd0;
    play = 1'b1;
    wait_nn(1);
    song = 2'd2;
    wait_done(2);
    in_range = 1'b1;
    foreach (nn_q[k]) if (nn_q[k][18:12] > 7'h1F) in_range = 1'b0;
    chk("latch_range", 32'(in_range), 32'd1);
    chk("latch_count", 32'(nn_q.size()), 32'd10);
    play = 1'b0;
    cyc_wait(3);

    // Raise play with song 2 latched, then pause in WAIT_NOTE with note_done forced.
    clear_q();
    play = 1'b1;
    c = cyc;
    wait_nn(1);
    if (nn_q.size() >= 1) begin
      chk("s2_first_addr", 32'(nn_q[0][18:12]), 32'h40);
      chk("s2_first_latency", 32'(nn_cyc_q[0]), 32'(c + 3));
    end
    play = 1'b0;
    force_done = 1'b1;
    cyc_wait(20);
    chk("pause_count", 32'(nn_q.size()), 32'd1);
    chk("pause_addr", 32'(rom_addr), 32'h40);
    play = 1'b1;
    c = cyc;
    wait_nn(2);
    force_done = 1'b0;
    if (nn_q.size() >= 2) begin
      chk("resume_latency", 32'(nn_cyc_q[1]), 32'(c + 3));
      chk("resume_addr", 32'(nn_q[1][18:12]), 32'h41);
    end
    wait_done(3);
    play = 1'b0;
    cyc_wait(3);

    // Full 32-note song with random pauses.
    clear_q();
    song = 2'd3;
    rand_en = 1'b1;
    wait_done(4);
    rand_en = 1'b0;
    play = 1'b0;
    chk("full_count", 32'(nn_q.size()), 32'd32);
    if (nn_q.size() >= 1) chk("full_last_addr", 32'(nn_q[nn_q.size()-1][18:12]), 32'h7F);
    chk("full_done_addr", 32'(sd_addr), 32'h7F);
    cyc_wait(3);

    // Reset in WAIT_NOTE at idx 5.
    clear_q();
    song = 2'd0;
    play = 1'b1;
    wait_nn(6);
    if (nn_q.size() >= 6) chk("rst_idx5_addr", 32'(nn_q[5][18:12]), 32'h05);
    d0 = done_cnt;
    reset = 1'b1;
    cyc_wait(1);
    reset = 1'b0;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_duration", 32'(duration), 32'd0);
    chk("rst_new_note", 32'(new_note), 32'd0);
    chk("rst_song_done", 32'(song_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    wait_nn(7);
    chk("rst_no_done", 32'(done_cnt), 32'(d0));
    if (nn_q.size() >= 7) chk("rst_restart_addr", 32'(nn_q[6][18:12]), 32'h00);
    wait_done(d0 + 1);
    chk("rst_final_done_addr", 32'(sd_addr), 32'h0A);
    play = 1'b0;
    cyc_wait(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/song_reader.md
# song_reader

Sequencer that walks a song's note list in the external song ROM and hands each note to the note timer and note player. It fetches the next `{note, duration}` word, issues it with a one-cycle `new_note` strobe, and waits for `note_done` from the timer before advancing. It signals the end of a song and honours play/pause. It sits between the top-level player FSM (which drives `play` and `song`) and the note timer.

## Interface
- `NOTES_PER_SONG_LOG2`, default 5: index width; 32 note slots per song.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `play`  in  1: level; 1 = run, 0 = pause or hold.
- `song`  in  2: song select; latched on leaving IDLE.
- `note_done`  in  1: from the note timer; 1 = current note finished.
- `beat`  in  1: beat strobe. Unused except for the pause rule below.
- `rom_addr`  out  7: `{song_q, idx}` to the song ROM.
- `rom_data`  in  12: `{note[11:6], duration[5:0]}`. Valid exactly 1 cycle after `rom_addr`.
- `note`  out  6: current note code. Registered.
- `duration`  out  6: current note length in beats. Registered.
- `new_note`  out  1: one-cycle strobe when `note`/`duration` become valid. Drives the timer's load input.
- `song_done`  out  1: one-cycle strobe at end of song.
- `busy`  out  1: high in every state except IDLE and END.

## Operation
- States:
  - IDLE: `idx`=0. Go to FETCH when `play`=1, latching `song` into `song_q`.
  - FETCH: drive `rom_addr`. Go to ROM_WAIT.
  - ROM_WAIT: capture `rom_data`.
    - If `duration` field = 0, this is the end-of-song marker: go to DONE.
    - Otherwise load the `note`/`duration` regs and go to ISSUE.
  - ISSUE: `new_note`=1 for this cycle only. Go to WAIT_NOTE.
  - WAIT_NOTE: leave when `note_done`=1 and `play`=1.
    - If `idx` = 31: go to DONE.
    - Otherwise `idx`+1 and go to FETCH.
  - DONE: `song_done`=1 for one cycle. Go to END.
  - END: hold until `play`=0, then go to IDLE.
- Pause (`play`=0):
  - FETCH, ROM_WAIT and ISSUE complete normally. The issue is not withheld mid-fetch.
  - WAIT_NOTE holds: `note_done` is ignored and `idx` does not advance.
  - The note timer pauses on its own. `beat` is not consumed here.
- `idx` is a 5-bit counter and never wraps silently. Reaching 31 and finishing that note ends the song even without a marker.
- `song` changes after latching are ignored until the next IDLE→FETCH transition.
- `note` and `duration` keep their last issued value through DONE, END and IDLE until the next ROM_WAIT capture.
- The end-of-song marker is never issued: no `new_note`, and `note`/`duration` are unchanged.

## Timing
- Reset:
  - State = IDLE; `idx`=0; `song_q`=0.
  - `rom_addr`=0, `note`=0, `duration`=0.
  - `new_note`=0, `song_done`=0, `busy`=0.
  - Reset mid-song aborts immediately with no `song_done` pulse.
- Fetch-to-issue latency: `rom_addr` is valid in FETCH (cycle F).
  - `rom_data` is captured at the end of F+1.
  - `new_note` and the new `note`/`duration` are visible in F+2.
- `note_done` is not sampled in ISSUE. The timer drives `note_done`=0 while its load is asserted, and the loaded count is non-zero from the next cycle. WAIT_NOTE sampling starts at F+3.
- Note-to-note gap: `note_done` sampled high at cycle T gives FETCH at T+1 and `new_note` at T+3.
- `song_done` is asserted exactly 1 cycle after the final ROM_WAIT (marker) or the final WAIT_NOTE exit.
- Simultaneous events:
  - `play` falling in the same cycle as `note_done`=1 in WAIT_NOTE: hold.
  - Reset together with any input: reset wins.

## Test plan
- Three-note song: ROM for song 1 holds (0x10,2), (0x12,3), (0x14,1), then the marker (x,0). Play=1, with the timer model answering `note_done` after N beats. Require:
  - `rom_addr` = 0x20, 0x21, 0x22, 0x23 in order.
  - Three `new_note` pulses carrying those values.
  - `song_done` 1 cycle after the marker capture.
  - `busy`=0 in END.
- Latency check: `note_done` pulsed at cycle 100 in WAIT_NOTE → `new_note` at cycle 103. First note: `play` rising at cycle 10 → `new_note` at cycle 13.
- Pause: `play`=0 while in WAIT_NOTE with `note_done` held 1 for 20 cycles → no `idx` change and no `new_note`. `play`=1 → `new_note` 3 cycles later.
- Full song: song 3 with 32 non-zero entries → 32 `new_note` pulses, last `rom_addr` = 0x7F, then `song_done`. `idx` does not wrap to 0x60 while playing.
- Song latch and END hold:
  - Change `song` 0→2 during playback → addresses stay in 0x00–0x1F.
  - Keep `play` high after `song_done` → stays in END.
  - Drop `play` → IDLE. Raise `play` → fetch 0x40.
- Reset mid-song: assert `reset` in WAIT_NOTE at `idx`=5 → next cycle all outputs are 0, with no `song_done`. Restart fetches `idx` 0.
